// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller arbitrating IF fetches and MEM loads/stores.
// Optional one-entry fetch buffer is enabled by defining MC_INST_BUF_EN.
module mem_ctrl #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int MEM_PRIORITY   = 1
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      IF_MCE_in,
   input  logic [31:0]               IF_MCAddr_in,
   input  logic                      IF_flush_in,
   output logic                      IF_instE_out,
   output logic [31:0]               IF_inst_out,
   output logic                      MC_busyIF_out,
   input  logic                      MEM_MCE_in,
   input  logic                      MEM_wr_in,
   input  logic [1:0]                MEM_size_in,
   input  logic [31:0]               MEM_addr_in,
   input  logic [31:0]               MEM_data_in,
   output logic                      MEM_dataE_out,
   output logic [31:0]               MEM_data_out,
   output logic                      MC_busyMEM_out,
   input  logic [7:0]                ram_din_in,
   output logic [7:0]                ram_dout_out,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_out,
   output logic                      ram_wr_out
);

   typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

   state_t state, state_nxt;
   logic [2:0]  cnt, cnt_nxt, len, len_nxt, cnt_m2;
   logic [31:0] addr, addr_nxt, wdata, wdata_nxt, rdata, rdata_nxt;
   logic        inst_e_nxt, busy_if_nxt, data_e_nxt, busy_mem_nxt, ram_wr_nxt;
   logic [31:0] inst_nxt, mdata_nxt;
   logic [7:0]  ram_dout_nxt;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr_nxt;
   logic        if_req, mem_win, if_win;
`ifdef MC_INST_BUF_EN
   logic        hit, hit_nxt, buf_valid, buf_valid_nxt;
   logic [31:0] buf_tag, buf_tag_nxt, buf_data, buf_data_nxt;
`endif

   function automatic logic [2:0] len_of(input logic [1:0] size);
      case (size)
         2'd0:    len_of = 3'd1;
         2'd1:    len_of = 3'd2;
         default: len_of = 3'd4;
      endcase
   endfunction

   assign if_req  = IF_MCE_in && !IF_flush_in;
   assign mem_win = MEM_MCE_in && (MEM_PRIORITY != 0 || !if_req);
   assign if_win  = if_req && !mem_win;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      len_nxt      = len;
      addr_nxt     = addr;
      wdata_nxt    = wdata;
      rdata_nxt    = rdata;
      inst_e_nxt   = 1'b0;
      inst_nxt     = IF_inst_out;
      busy_if_nxt  = 1'b0;
      data_e_nxt   = 1'b0;
      mdata_nxt    = MEM_data_out;
      busy_mem_nxt = 1'b0;
      ram_dout_nxt = '0;
      ram_addr_nxt = '0;
      ram_wr_nxt   = 1'b0;
      cnt_m2       = cnt - 3'd2;
`ifdef MC_INST_BUF_EN
      hit_nxt       = hit;
      buf_valid_nxt = buf_valid;
      buf_tag_nxt   = buf_tag;
      buf_data_nxt  = buf_data;
`endif
      case (state)
         // DONE doubles as an accept cycle so back-to-back requests lose no cycle
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (mem_win) begin
               addr_nxt     = MEM_addr_in;
               len_nxt      = len_of(MEM_size_in);
               wdata_nxt    = MEM_data_in;
               rdata_nxt    = '0;
               cnt_nxt      = 3'd1;
               busy_mem_nxt = 1'b1;
               ram_addr_nxt = MEM_addr_in[RAM_ADDR_WIDTH-1:0];
               if (MEM_wr_in) begin
                  state_nxt    = MEM_WR;
                  ram_wr_nxt   = 1'b1;
                  ram_dout_nxt = MEM_data_in[7:0];
`ifdef MC_INST_BUF_EN
                  buf_valid_nxt = 1'b0;
`endif
               end else begin
                  state_nxt = MEM_RD;
               end
            end else if (if_win) begin
               state_nxt   = IF_RD;
               addr_nxt    = IF_MCAddr_in;
               len_nxt     = 3'd4;
               rdata_nxt   = '0;
               cnt_nxt     = 3'd1;
               busy_if_nxt = 1'b1;
`ifdef MC_INST_BUF_EN
               hit_nxt = buf_valid && (buf_tag == IF_MCAddr_in);
               if (!hit_nxt)
                  ram_addr_nxt = IF_MCAddr_in[RAM_ADDR_WIDTH-1:0];
`else
               ram_addr_nxt = IF_MCAddr_in[RAM_ADDR_WIDTH-1:0];
`endif
            end
         end
         IF_RD, MEM_RD: begin
            if (state == IF_RD && IF_flush_in) begin
               state_nxt = IDLE;
`ifdef MC_INST_BUF_EN
               hit_nxt = 1'b0;
            end else if (hit) begin
               state_nxt   = DONE;
               hit_nxt     = 1'b0;
               inst_e_nxt  = 1'b1;
               inst_nxt    = buf_data;
               busy_if_nxt = 1'b1;
`endif
            end else begin
               busy_if_nxt  = (state == IF_RD);
               busy_mem_nxt = (state == MEM_RD);
               cnt_nxt      = cnt + 3'd1;
               if (cnt < len)
                  ram_addr_nxt = RAM_ADDR_WIDTH'(addr + {29'd0, cnt});
               // RAM data lags its address by one cycle, so byte k lands two edges after Ek
               if (cnt >= 3'd2)
                  rdata_nxt = rdata | (32'(ram_din_in) << {cnt_m2[1:0], 3'b000});
               if (cnt == len + 3'd1) begin
                  state_nxt = DONE;
                  if (state == IF_RD) begin
                     inst_e_nxt = 1'b1;
                     inst_nxt   = rdata_nxt;
`ifdef MC_INST_BUF_EN
                     buf_valid_nxt = 1'b1;
                     buf_tag_nxt   = addr;
                     buf_data_nxt  = rdata_nxt;
`endif
                  end else begin
                     data_e_nxt = 1'b1;
                     mdata_nxt  = rdata_nxt;
                  end
               end
            end
         end
         MEM_WR: begin
            busy_mem_nxt = 1'b1;
            if (cnt < len) begin
               ram_wr_nxt   = 1'b1;
               ram_addr_nxt = RAM_ADDR_WIDTH'(addr + {29'd0, cnt});
               ram_dout_nxt = 8'(wdata >> {cnt[1:0], 3'b000});
               cnt_nxt      = cnt + 3'd1;
            end else begin
               state_nxt  = DONE;
               data_e_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         cnt            <= '0;
         len            <= '0;
         addr           <= '0;
         wdata          <= '0;
         rdata          <= '0;
         IF_instE_out   <= 1'b0;
         IF_inst_out    <= '0;
         MC_busyIF_out  <= 1'b0;
         MEM_dataE_out  <= 1'b0;
         MEM_data_out   <= '0;
         MC_busyMEM_out <= 1'b0;
         ram_dout_out   <= '0;
         ram_addr_out   <= '0;
         ram_wr_out     <= 1'b0;
`ifdef MC_INST_BUF_EN
         hit            <= 1'b0;
         buf_valid      <= 1'b0;
         buf_tag        <= '0;
         buf_data       <= '0;
`endif
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         len            <= len_nxt;
         addr           <= addr_nxt;
         wdata          <= wdata_nxt;
         rdata          <= rdata_nxt;
         IF_instE_out   <= inst_e_nxt;
         IF_inst_out    <= inst_nxt;
         MC_busyIF_out  <= busy_if_nxt;
         MEM_dataE_out  <= data_e_nxt;
         MEM_data_out   <= mdata_nxt;
         MC_busyMEM_out <= busy_mem_nxt;
         ram_dout_out   <= ram_dout_nxt;
         ram_addr_out   <= ram_addr_nxt;
         ram_wr_out     <= ram_wr_nxt;
`ifdef MC_INST_BUF_EN
         hit            <= hit_nxt;
         buf_valid      <= buf_valid_nxt;
         buf_tag        <= buf_tag_nxt;
         buf_data       <= buf_data_nxt;
`endif
      end
   end

endmodule
